// File: rtl/fp_add_subt_responder_if.sv
// rtl/fp_add_subt_responder_if.sv - add/subt request/response handshake bundle
interface fp_add_subt_responder_if #(
    parameter int W = 32
);
    logic         beg_add_subt;
    logic         ack_add_subt;
    logic         op_add_subt;
    logic [W-1:0] add_subt_dataA;
    logic [W-1:0] add_subt_dataB;
    logic         ready_add_subt;
    logic [W-1:0] result_add_subt;

    modport master (
        output beg_add_subt,
        output ack_add_subt,
        output op_add_subt,
        output add_subt_dataA,
        output add_subt_dataB,
        input  ready_add_subt,
        input  result_add_subt
    );

    modport slave (
        input  beg_add_subt,
        input  ack_add_subt,
        input  op_add_subt,
        input  add_subt_dataA,
        input  add_subt_dataB,
        output ready_add_subt,
        output result_add_subt
    );
endinterface

// File: rtl/fp_add_subt_responder.sv
// rtl/fp_add_subt_responder.sv - multi-cycle IEEE-754 add/subtract responder
// Build option ADD_SUBT_ROUND_NEAREST_EN: round-to-nearest-even; otherwise truncation.
module fp_add_subt_responder #(
    parameter int W = 32,
    parameter int E = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    fp_add_subt_responder_if.slave bus
);
    localparam int SW  = W - E - 1;
    localparam int MW  = SW + 4;
    localparam int WW  = 2 * MW - 1;
    localparam int XW  = E + 2;
    localparam int LZW = $clog2(MW + 1);
    localparam logic [E-1:0]         MAX_SHIFT = E'(SW + 3);
    localparam logic signed [XW-1:0] EXP_INF   = XW'((1 << E) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO  = '0;
    localparam logic signed [XW-1:0] EXP_ONE   = XW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]         a_q, b_q;
    logic                 sign_q, sign_d;
    logic                 eff_sub_q, eff_sub_d;
    logic signed [XW-1:0] exp_q, exp_align, exp_norm;
    logic [MW-1:0]        mx_q, mx_d, my_q, my_d;
    logic [MW:0]          sum_q, sum_d;
    logic [MW-1:0]        norm_q, norm_d;
    logic [W-1:0]         result_q, result_d;
    logic                 ready_q, ready_d;
    logic                 cap_en, align_en, add_en, norm_en, round_en;

    logic [W-2:0]         mag_a, mag_b, mag_x, mag_y;
    logic                 swap;
    logic [E-1:0]         ex, ey, diff;
    logic [SW:0]          mant_x, mant_y;
    logic [WW-1:0]        y_wide;
    logic [LZW-1:0]       lz;
    logic signed [XW-1:0] exp_r;
    logic [SW-1:0]        frac_r;
`ifdef ADD_SUBT_ROUND_NEAREST_EN
    logic                 round_up;
    logic [SW+1:0]        rnd;
    logic                 unused_hidden;
`else
    logic                 unused_grs;
`endif

    function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
        lzc = LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (v[i]) lzc = LZW'(MW - 1 - i);
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.beg_add_subt) state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (bus.ack_add_subt && ready_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ready trails the result write by one edge, so ack is only honoured once ready is visible
    always_comb begin
        cap_en   = (state_q == IDLE) && bus.beg_add_subt;
        align_en = (state_q == ALIGN);
        add_en   = (state_q == ADD);
        norm_en  = (state_q == NORM);
        round_en = (state_q == ROUND);
        ready_d  = (state_q == DONE) && !(bus.ack_add_subt && ready_q);
    end

    // Zero/subnormal operands are flushed to a zero magnitude before ordering
    always_comb begin
        mag_a     = (a_q[W-2:SW] == '0) ? '0 : a_q[W-2:0];
        mag_b     = (b_q[W-2:SW] == '0) ? '0 : b_q[W-2:0];
        swap      = mag_b > mag_a;
        mag_x     = swap ? mag_b : mag_a;
        mag_y     = swap ? mag_a : mag_b;
        sign_d    = swap ? b_q[W-1] : a_q[W-1];
        eff_sub_d = a_q[W-1] ^ b_q[W-1];
        ex        = mag_x[W-2:SW];
        ey        = mag_y[W-2:SW];
        diff      = ex - ey;
        mant_x    = {ex != '0, mag_x[SW-1:0]};
        mant_y    = {ey != '0, mag_y[SW-1:0]};
        mx_d      = {mant_x, 3'b000};
        y_wide    = {mant_y, {(WW-SW-1){1'b0}}} >> diff;
        if (diff > MAX_SHIFT)
            my_d = {{(MW-1){1'b0}}, |mant_y};
        else
            my_d = {y_wide[WW-1 -: MW-1], y_wide[WW-MW] | (|y_wide[WW-MW-1:0])};
        exp_align = $signed({{(XW-E){1'b0}}, ex});
    end

    always_comb begin
        if (eff_sub_q) sum_d = {1'b0, mx_q} - {1'b0, my_q};
        else           sum_d = {1'b0, mx_q} + {1'b0, my_q};
    end

    always_comb begin
        lz = lzc(sum_q[MW-1:0]);
        if (sum_q[MW]) begin
            norm_d   = {sum_q[MW:2], sum_q[1] | sum_q[0]};
            exp_norm = exp_q + EXP_ONE;
        end else begin
            norm_d   = sum_q[MW-1:0] << lz;
            exp_norm = exp_q - $signed({{(XW-LZW){1'b0}}, lz});
        end
    end

    // norm_q = {hidden, fraction, G, R, S}; hidden clear means the sum cancelled to zero
    always_comb begin
`ifdef ADD_SUBT_ROUND_NEAREST_EN
        round_up      = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
        rnd           = {1'b0, norm_q[MW-1:3]} + {{(SW+1){1'b0}}, round_up};
        unused_hidden = rnd[SW];
        frac_r        = rnd[SW-1:0];
        exp_r         = exp_q + $signed({{(XW-1){1'b0}}, rnd[SW+1]});
`else
        unused_grs    = ^norm_q[2:0];
        frac_r        = norm_q[MW-2:3];
        exp_r         = exp_q;
`endif
        if (!norm_q[MW-1])
            result_d = '0;
        else if (exp_r >= EXP_INF)
            result_d = {sign_q, {E{1'b1}}, {SW{1'b0}}};
        else if (exp_r <= EXP_ZERO)
            result_d = {sign_q, {(W-1){1'b0}}};
        else
            result_d = {sign_q, exp_r[E-1:0], frac_r};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            exp_q     <= '0;
            mx_q      <= '0;
            my_q      <= '0;
            sum_q     <= '0;
            norm_q    <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            if (cap_en) begin
                a_q <= bus.add_subt_dataA;
                b_q <= {bus.add_subt_dataB[W-1] ^ bus.op_add_subt, bus.add_subt_dataB[W-2:0]};
            end
            if (align_en) begin
                sign_q    <= sign_d;
                eff_sub_q <= eff_sub_d;
                exp_q     <= exp_align;
                mx_q      <= mx_d;
                my_q      <= my_d;
            end else if (norm_en) begin
                exp_q     <= exp_norm;
            end
            if (add_en)   sum_q    <= sum_d;
            if (norm_en)  norm_q   <= norm_d;
            if (round_en) result_q <= result_d;
            ready_q <= ready_d;
        end
    end

    assign bus.ready_add_subt  = ready_q;
    assign bus.result_add_subt = result_q;

endmodule

// File: tb/tb_fp_add_subt_responder.sv
// tb/tb_fp_add_subt_responder.sv - scoreboard bench for fp_add_subt_responder
module tb_fp_add_subt_responder;
    localparam int W = 32;
`ifdef ADD_SUBT_ROUND_NEAREST_EN
    localparam logic [W-1:0] T4_RES = 32'h3F800002;
`else
    localparam logic [W-1:0] T4_RES = 32'h3F800001;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    fp_add_subt_responder_if #(.W(W)) bus ();

    fp_add_subt_responder #(.W(W), .E(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        int           start;
        string        name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_vec    = 0;
    int   n_bad    = 0;
    logic rdy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            $display("FAIL %s: got %h, need %h", nm, act, exp_v);
            n_bad++;
        end
    endtask

    // monitor: every rising ready pops one expected response
    always @(negedge clk) begin
        if (bus.ready_add_subt === 1'b1 && rdy_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ready: got result %h, need no response", bus.result_add_subt);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_result"}, bus.result_add_subt, mon_e.res);
                check({mon_e.name, "_latency"}, W'(cyc - mon_e.start), W'(5));
            end
        end
        rdy_prev <= bus.ready_add_subt;
    end

    task automatic push_exp(input logic [W-1:0] res, input string nm);
        exp_t e;
        e.res   = res;
        e.start = cyc;
        e.name  = nm;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                         input logic [W-1:0] res, input string nm);
        @(negedge clk);
        bus.add_subt_dataA = a;
        bus.add_subt_dataB = b;
        bus.op_add_subt    = op;
        bus.beg_add_subt   = 1'b1;
        @(posedge clk);
        #1;
        push_exp(res, nm);
        bus.beg_add_subt = 1'b0;
    endtask

    task automatic wait_ready(input string nm, output bit ok);
        exp_t drop;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.ready_add_subt === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: got ready 0 after 20 cycles, need ready 1", nm);
            if (sb_q.size() > 0) drop = sb_q.pop_front();
        end
    endtask

    task automatic ack_now(input string nm);
        bus.ack_add_subt = 1'b1;
        @(posedge clk);
        #1;
        bus.ack_add_subt = 1'b0;
        check({nm, "_ack_clears_ready"}, W'(bus.ready_add_subt), W'(0));
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                       input logic [W-1:0] res, input string nm);
        bit ok;
        issue(a, b, op, res, nm);
        wait_ready(nm, ok);
        if (ok) ack_now(nm);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, need finish within 300000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        bit   stable;
        exp_t drop;

        bus.beg_add_subt   = 1'b0;
        bus.ack_add_subt   = 1'b0;
        bus.op_add_subt    = 1'b0;
        bus.add_subt_dataA = '0;
        bus.add_subt_dataB = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", W'(bus.ready_add_subt), W'(0));
        check("reset_result", bus.result_add_subt, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, "t1_one_plus_one");
        run(32'h3FC00000, 32'hBE800000, 1'b0, 32'h3FA00000, "t2_add_neg");
        run(32'h3FC00000, 32'h3E800000, 1'b1, 32'h3FA00000, "t2_sub_pos");
        run(32'h3F1B74EE, 32'h3F1B74EE, 1'b1, 32'h00000000, "t3_cancel");
        run(32'h3F1B74EE, 32'h00000000, 1'b1, 32'h3F1B74EE, "t3_minus_zero");
        run(32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, "zero_minus_one");
        run(32'h3F800001, 32'h33800000, 1'b0, T4_RES,       "t4_tie_round");
        run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, "t4_overflow_inf");
        run(32'h40400000, 32'h40A00000, 1'b1, 32'hC0000000, "swap_sub_norm");
        run(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, "underflow_flush");

        // result and ready must hold while ack stays low
        issue(32'h3FC00000, 32'hBE800000, 1'b0, 32'h3FA00000, "hold");
        wait_ready("hold", ok);
        if (ok) begin
            stable = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (bus.ready_add_subt !== 1'b1 || bus.result_add_subt !== 32'h3FA00000) stable = 1'b0;
            end
            check("hold_stable", W'(stable), W'(1));
            ack_now("hold");
        end

        // beg pulsed during ALIGN and ADD with different operands must be ignored
        issue(32'h40400000, 32'h40A00000, 1'b1, 32'hC0000000, "beg_ignored");
        bus.add_subt_dataA = 32'h3F800000;
        bus.add_subt_dataB = 32'h3F800000;
        bus.op_add_subt    = 1'b0;
        bus.beg_add_subt   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.beg_add_subt = 1'b0;
        wait_ready("beg_ignored", ok);
        if (ok) ack_now("beg_ignored");
        repeat (8) @(negedge clk);
        check("no_restart_ready", W'(bus.ready_add_subt), W'(0));

        // beg and ack together in DONE: ack wins, held beg starts a new op one edge later
        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, "begack_first");
        wait_ready("begack_first", ok);
        if (ok) begin
            bus.add_subt_dataA = 32'h3FC00000;
            bus.add_subt_dataB = 32'h3E800000;
            bus.op_add_subt    = 1'b1;
            bus.beg_add_subt   = 1'b1;
            bus.ack_add_subt   = 1'b1;
            @(posedge clk);
            #1;
            bus.ack_add_subt = 1'b0;
            check("begack_ready_drop", W'(bus.ready_add_subt), W'(0));
            @(posedge clk);
            #1;
            push_exp(32'h3FA00000, "begack_second");
            bus.beg_add_subt = 1'b0;
            wait_ready("begack_second", ok);
            if (ok) ack_now("begack_second");
        end

        // asynchronous reset while in NORM aborts the operation
        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, "rst_abort");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_ready", W'(bus.ready_add_subt), W'(0));
        check("rst_async_result", bus.result_add_subt, 32'h0);
        drop = sb_q.pop_back();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_no_partial", W'(bus.ready_add_subt), W'(0));
        run(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, "t6_after_reset");

        repeat (3) @(negedge clk);
        check("queue_empty", W'(sb_q.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
